// File: rtl/jt12_pkg.sv
// Shared jt12 definitions: slot-group layout, carrier decode and mix saturation.
package jt12_pkg;

    localparam int unsigned NUM_CH    = 6;
    localparam int unsigned NUM_SLOTS = 24;
    localparam int unsigned S1_BASE   = 0;
    localparam int unsigned S3_BASE   = 6;
    localparam int unsigned S2_BASE   = 12;
    localparam int unsigned S4_BASE   = 18;

    localparam int unsigned SLOT_W = 5;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned ALG_W  = 3;
    localparam int unsigned OP_W   = 9;
    localparam int unsigned SUM_W  = 11;
    localparam int unsigned MIX_W  = 14;
    localparam int unsigned OUT_W  = 12;
    localparam int unsigned DAC_W  = 8;

    localparam logic signed [MIX_W-1:0] MIX_MAX = 14'sh07FF;
    localparam logic signed [MIX_W-1:0] MIX_MIN = 14'sh3800;
    localparam logic signed [OUT_W-1:0] OUT_MAX = 12'sh7FF;
    localparam logic signed [OUT_W-1:0] OUT_MIN = 12'sh800;

    // Operator groups in slot order: S1, S3, S2, S4.
    typedef enum logic [1:0] {
        GRP_S1 = 2'd0,
        GRP_S3 = 2'd1,
        GRP_S2 = 2'd2,
        GRP_S4 = 2'd3
    } op_grp_e;

    // Operator group owning a slot.
    function automatic op_grp_e slot_grp(input logic [SLOT_W-1:0] slot);
        op_grp_e grp;
        grp = GRP_S1;
        if (slot >= SLOT_W'(S4_BASE))      grp = GRP_S4;
        else if (slot >= SLOT_W'(S2_BASE)) grp = GRP_S2;
        else if (slot >= SLOT_W'(S3_BASE)) grp = GRP_S3;
        return grp;
    endfunction

    // Channel owning a slot (slot mod 6).
    function automatic logic [CH_W-1:0] slot_ch(input logic [SLOT_W-1:0] slot);
        logic [SLOT_W-1:0] base;
        base = SLOT_W'(S1_BASE);
        case (slot_grp(slot))
            GRP_S3:  base = SLOT_W'(S3_BASE);
            GRP_S2:  base = SLOT_W'(S2_BASE);
            GRP_S4:  base = SLOT_W'(S4_BASE);
            default: base = SLOT_W'(S1_BASE);
        endcase
        return CH_W'(slot - base);
    endfunction

    // True when the operator in this group is a carrier for the algorithm.
    function automatic logic is_carrier(input op_grp_e grp, input logic [ALG_W-1:0] alg);
        logic car;
        car = 1'b1;
        case (grp)
            GRP_S1:  car = (alg == ALG_W'(7));
            GRP_S3:  car = (alg >= ALG_W'(5));
            GRP_S2:  car = (alg >= ALG_W'(4));
            default: car = 1'b1;
        endcase
        return car;
    endfunction

    // Clamp a mix accumulator to the 12-bit output range.
    function automatic logic signed [OUT_W-1:0] sat_mix(input logic signed [MIX_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        r = OUT_W'(v);
        if (v > MIX_MAX)      r = OUT_MAX;
        else if (v < MIX_MIN) r = OUT_MIN;
        return r;
    endfunction

endpackage

// File: rtl/jt12_sh_rst.sv
// Resettable fixed-length shift register; drop_o is din_i delayed by STAGES enabled cycles.
module jt12_sh_rst #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned STAGES = 6
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] drop_o
);

    logic [WIDTH-1:0] bits_q [STAGES];

    // Advance every stage by one; reset clears all stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) bits_q[i] <= '0;
        end else if (en_i) begin
            bits_q[0] <= din_i;
            for (int unsigned i = 1; i < STAGES; i++) bits_q[i] <= bits_q[i-1];
        end
    end

    assign drop_o = bits_q[STAGES-1];

endmodule

// File: rtl/jt12_acc.sv
// FM channel accumulator: sums carrier operators per channel and mixes channels into a stereo sample.
module jt12_acc
    import jt12_pkg::*;
(
    input  logic                    rst,
    input  logic                    clk,
    input  logic                    zero,
    input  logic signed [OP_W-1:0]  op_result,
    input  logic [ALG_W-1:0]        alg,
    input  logic                    pan_l,
    input  logic                    pan_r,
    input  logic                    dac_en,
    input  logic [DAC_W-1:0]        dac_data,
    output logic signed [SUM_W-1:0] ch_out,
    output logic [CH_W-1:0]         ch_num,
    output logic                    ch_valid,
    output logic signed [OUT_W-1:0] left,
    output logic signed [OUT_W-1:0] right,
    output logic                    sample
);

    logic [SLOT_W-1:0]        slot_q, slot_d, slot_c;
    op_grp_e                  grp_c;
    logic [CH_W-1:0]          ch_c;
    logic                     last_c;
    logic signed [SUM_W-1:0]  contrib_c, head_c, sum_c;
    logic signed [MIX_W-1:0]  gated_l_c, gated_r_c;
    logic signed [MIX_W-1:0]  mix_l_q, mix_l_d, mix_r_q, mix_r_d;
    logic signed [SUM_W-1:0]  ch_out_q, ch_out_d;
    logic [CH_W-1:0]          ch_num_q, ch_num_d;
    logic                     ch_valid_q, ch_valid_d;
    logic signed [OUT_W-1:0]  left_q, left_d, right_q, right_d;
    logic                     sample_q, sample_d;

    // Per-channel partial sums circulate with a 6-cycle period, one stage per channel.
    jt12_sh_rst #(
        .WIDTH  (SUM_W),
        .STAGES (NUM_CH)
    ) u_psum (
        .rst    (rst),
        .clk    (clk),
        .en_i   (1'b1),
        .din_i  (sum_c),
        .drop_o (head_c)
    );

    // Slot decode, channel sum update, stereo mix and output next-state.
    always_comb begin
        slot_c     = zero ? '0 : slot_q;
        grp_c      = slot_grp(slot_c);
        ch_c       = slot_ch(slot_c);
        last_c     = (slot_c == SLOT_W'(NUM_SLOTS - 1));
        contrib_c  = is_carrier(grp_c, alg) ? SUM_W'(op_result) : '0;
        sum_c      = (grp_c == GRP_S1) ? contrib_c : head_c + contrib_c;
        if (last_c && dac_en) sum_c = {dac_data ^ 8'h80, 3'b000};

        gated_l_c  = pan_l ? MIX_W'(sum_c) : '0;
        gated_r_c  = pan_r ? MIX_W'(sum_c) : '0;
        mix_l_d    = mix_l_q;
        mix_r_d    = mix_r_q;
        if (grp_c == GRP_S4) begin
            if (slot_c == SLOT_W'(S4_BASE)) begin
                mix_l_d = gated_l_c;
                mix_r_d = gated_r_c;
            end else begin
                mix_l_d = mix_l_q + gated_l_c;
                mix_r_d = mix_r_q + gated_r_c;
            end
        end

        left_d     = last_c ? sat_mix(mix_l_d) : left_q;
        right_d    = last_c ? sat_mix(mix_r_d) : right_q;
        sample_d   = last_c;
        ch_valid_d = (grp_c == GRP_S4);
        ch_out_d   = ch_valid_d ? sum_c : ch_out_q;
        ch_num_d   = ch_valid_d ? ch_c : ch_num_q;
        slot_d     = last_c ? '0 : slot_c + 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            mix_l_q    <= '0;
            mix_r_q    <= '0;
            ch_out_q   <= '0;
            ch_num_q   <= '0;
            ch_valid_q <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            sample_q   <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            mix_l_q    <= mix_l_d;
            mix_r_q    <= mix_r_d;
            ch_out_q   <= ch_out_d;
            ch_num_q   <= ch_num_d;
            ch_valid_q <= ch_valid_d;
            left_q     <= left_d;
            right_q    <= right_d;
            sample_q   <= sample_d;
        end
    end

    assign ch_out   = ch_out_q;
    assign ch_num   = ch_num_q;
    assign ch_valid = ch_valid_q;
    assign left     = left_q;
    assign right    = right_q;
    assign sample   = sample_q;

endmodule

// File: tb/tb_jt12_acc.sv
// Bench for jt12_acc: directed frame table, reset/resync sequence and random frames against a slot-level model.
module tb_jt12_acc;

    logic               rst, clk, zero;
    logic signed [8:0]  op_result;
    logic [2:0]         alg;
    logic               pan_l, pan_r, dac_en;
    logic [7:0]         dac_data;
    logic signed [10:0] ch_out;
    logic [2:0]         ch_num;
    logic               ch_valid;
    logic signed [11:0] left, right;
    logic               sample;

    jt12_acc dut (
        .rst       (rst),
        .clk       (clk),
        .zero      (zero),
        .op_result (op_result),
        .alg       (alg),
        .pan_l     (pan_l),
        .pan_r     (pan_r),
        .dac_en    (dac_en),
        .dac_data  (dac_data),
        .ch_out    (ch_out),
        .ch_num    (ch_num),
        .ch_valid  (ch_valid),
        .left      (left),
        .right     (right),
        .sample    (sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame position, per-channel sums and mix totals as plain integers.
    int m_slot;
    int m_psum [6];
    int m_mix_l, m_mix_r;
    int e_ch_out, e_ch_num, e_left, e_right;
    bit e_valid, e_sample;

    typedef struct {
        int alg;
        int op;
        int op_s4;
        bit pan_l;
        bit pan_r;
        bit dac_en;
        int dac_data;
        int exp_ch0;
        int exp_ch5;
        int exp_left;
        int exp_right;
    } vec_t;

    vec_t tab [9];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic void model_reset();
        m_slot = 0;
        foreach (m_psum[i]) m_psum[i] = 0;
        m_mix_l = 0; m_mix_r = 0;
        e_ch_out = 0; e_ch_num = 0; e_left = 0; e_right = 0;
        e_valid = 1'b0; e_sample = 1'b0;
    endfunction

    // Advance the model by one slot using the inputs currently applied.
    function automatic void model_step();
        int cur, grp, ch, c;
        bit car;
        cur = zero ? 0 : m_slot;
        grp = cur / 6;
        ch  = cur % 6;
        case (grp)
            0:       car = (alg == 3'd7);
            1:       car = (alg >= 3'd5);
            2:       car = (alg >= 3'd4);
            default: car = 1'b1;
        endcase
        c = car ? int'(op_result) : 0;
        if (grp == 0) m_psum[ch] = c;
        else          m_psum[ch] = m_psum[ch] + c;
        if (cur == 23 && dac_en) m_psum[5] = (int'(dac_data) - 128) * 8;
        e_valid  = (grp == 3);
        e_sample = (cur == 23);
        if (grp == 3) begin
            e_ch_out = m_psum[ch];
            e_ch_num = ch;
            if (cur == 18) begin m_mix_l = 0; m_mix_r = 0; end
            if (pan_l) m_mix_l = m_mix_l + m_psum[ch];
            if (pan_r) m_mix_r = m_mix_r + m_psum[ch];
            if (cur == 23) begin
                e_left  = clamp12(m_mix_l);
                e_right = clamp12(m_mix_r);
            end
        end
        m_slot = (cur == 23) ? 0 : cur + 1;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ch_out"},   int'(ch_out),   0);
        check({tag, "_ch_num"},   int'(ch_num),   0);
        check({tag, "_ch_valid"}, int'(ch_valid), 0);
        check({tag, "_left"},     int'(left),     0);
        check({tag, "_right"},    int'(right),    0);
        check({tag, "_sample"},   int'(sample),   0);
    endtask

    // Apply one slot of inputs, clock it and compare against the model.
    task automatic cycle(input bit z, input int op, input int a, input bit pl, input bit pr,
                         input bit de, input int dd);
        zero = z; op_result = 9'(op); alg = 3'(a);
        pan_l = pl; pan_r = pr; dac_en = de; dac_data = 8'(dd);
        model_step();
        @(posedge clk); #1;
        check("ch_valid", int'(ch_valid), int'(e_valid));
        check("sample",   int'(sample),   int'(e_sample));
        if (e_valid) begin
            check("ch_out", int'(ch_out), e_ch_out);
            check("ch_num", int'(ch_num), e_ch_num);
        end
        check("left",  int'(left),  e_left);
        check("right", int'(right), e_right);
    endtask

    // One aligned frame with uniform settings; reports what the DUT produced.
    task automatic run_frame(input vec_t v, output int got0, output int got5, output int t0,
                             output int gl, output int gr, output int nsamp);
        got0 = -9999; got5 = -9999; t0 = -1; gl = -9999; gr = -9999; nsamp = 0;
        for (int s = 0; s < 24; s++) begin
            cycle(s == 0, (s >= 18) ? v.op_s4 : v.op, v.alg, v.pan_l, v.pan_r, v.dac_en, v.dac_data);
            if (ch_valid && ch_num == 3'd0) begin got0 = int'(ch_out); t0 = s; end
            if (ch_valid && ch_num == 3'd5) got5 = int'(ch_out);
            if (sample) begin gl = int'(left); gr = int'(right); nsamp++; end
        end
    endtask

    initial begin
        int g0, g5, t0, gl, gr, ns, pre_samp;
        bit z;

        tab[0] = '{7, 100, 100, 1'b1, 1'b1, 1'b0, 0,   400,   400,  2047,  2047};
        tab[1] = '{0, 100, -50, 1'b1, 1'b1, 1'b0, 0,   -50,   -50,  -300,  -300};
        tab[2] = '{7, 255, 255, 1'b1, 1'b1, 1'b0, 0,  1020,  1020,  2047,  2047};
        tab[3] = '{7, -256, -256, 1'b1, 1'b0, 1'b0, 0, -1024, -1024, -2048,    0};
        tab[4] = '{7, 100, 100, 1'b1, 1'b1, 1'b1, 0,   400, -1024,   976,   976};
        tab[5] = '{7, 10,  10,  1'b1, 1'b1, 1'b1, 255,  40,  1016,  1216,  1216};
        tab[6] = '{4, 30,  30,  1'b0, 1'b1, 1'b0, 0,    60,    60,     0,   360};
        tab[7] = '{5, -20, -20, 1'b1, 1'b1, 1'b0, 0,   -60,   -60,  -360,  -360};
        tab[8] = '{6, 50,  -7,  1'b1, 1'b1, 1'b0, 0,    93,    93,   558,   558};

        rst = 1'b1; zero = 1'b0; op_result = '0; alg = '0;
        pan_l = 1'b0; pan_r = 1'b0; dac_en = 1'b0; dac_data = '0;
        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;

        // Directed frames.
        for (int i = 0; i < 9; i++) begin
            run_frame(tab[i], g0, g5, t0, gl, gr, ns);
            check($sformatf("tab%0d_ch0", i),    g0, tab[i].exp_ch0);
            check($sformatf("tab%0d_ch5", i),    g5, tab[i].exp_ch5);
            check($sformatf("tab%0d_ch0_t", i),  t0, 18);
            check($sformatf("tab%0d_left", i),   gl, tab[i].exp_left);
            check($sformatf("tab%0d_right", i),  gr, tab[i].exp_right);
            check($sformatf("tab%0d_nsamp", i),  ns, 1);
        end

        // Reset pulsed at slot 11, then a resync 7 cycles after release.
        for (int s = 0; s < 11; s++) cycle(s == 0, 100, 7, 1'b1, 1'b1, 1'b0, 0);
        zero = 1'b0; op_result = 9'sd100; alg = 3'd7;
        #2; rst = 1'b1; #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk); #1;
        check_zero("rst_held");
        rst = 1'b0;
        pre_samp = 0;
        for (int s = 0; s < 7; s++) begin
            cycle(1'b0, 100, 7, 1'b1, 1'b1, 1'b0, 0);
            if (sample) pre_samp++;
        end
        check("rst_no_early_sample", pre_samp, 0);
        for (int k = 0; k < 2; k++) begin
            run_frame(tab[0], g0, g5, t0, gl, gr, ns);
            check("rst_frame_ch0",   g0, 400);
            check("rst_frame_left",  gl, 2047);
            check("rst_frame_nsamp", ns, 1);
        end

        // Random traffic with occasional mid-frame resync.
        for (int n = 0; n < 1200; n++) begin
            z = (m_slot == 0) || ($urandom_range(0, 59) == 0);
            cycle(z, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
